audio_feed_sample_reader: RTL and testbench
===========================================

Name: audio_feed_sample_reader

Overview:
Downstream consumer of the 80000 x 32-bit on-chip sample memory. Sequentially reads packed stereo words (left = [31:16], right = [15:0]) over the memory's single-port slave interface and presents them as a ready/valid stream to the codec serializer. Credit-based prefetch into a small FIFO hides the memory's fixed 1-cycle read latency. Supports one-shot and looped playback.

Parameters:
ADDR_W, 17, memory word-address width
DATA_W, 32, memory/stream word width
MEM_WORDS, 80000, memory depth; upper clamp for length
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin playback at address 0 (ignored while busy)
stop  in  1  one-cycle pulse: abort playback and flush
loop_en  in  1  sampled at start; 1 = wrap to 0 after last word
length  in  ADDR_W  words to play; sampled at start
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on natural completion (not on stop)
mem_address  out  ADDR_W  memory word address
mem_chipselect  out  1  read request strobe
mem_write  out  1  constant 0
mem_byteenable  out  4  constant 4'hF
mem_clken  out  1  constant 1
mem_readdata  in  DATA_W  valid exactly 1 cycle after chipselect
src_data  out  DATA_W  stereo sample word
src_valid  out  1  src_data valid
src_ready  in  1  sink accepts when valid & ready

Behaviour:
- Reset: busy=0, done=0, mem_chipselect=0, mem_address=0, src_valid=0, FIFO empty, state IDLE, inflight=0.
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 -> latch len_q = min(length, MEM_WORDS), loop_q = loop_en, addr=0, busy=1 next cycle. If length==0: stay IDLE, pulse done next cycle, busy stays 0.
- FETCH: issue read (mem_chipselect=1, mem_address=addr) when fifo_count + inflight < FIFO_DEPTH. inflight is 1 the cycle after an issue, else 0. Issued word is written to FIFO the following cycle from mem_readdata.
- Address advance on each issue: if addr == len_q-1 then (loop_q ? addr=0, stay FETCH : go DRAIN), else addr+1. No address beyond len_q-1 is ever driven.
- DRAIN: no issues; when inflight==0 and FIFO empty -> IDLE, busy=0, done=1 for one cycle.
- Stream: src_valid = FIFO not empty; src_data = FIFO head (first-word fall-through). Pop on src_valid & src_ready. Push and pop in the same cycle are legal when full or empty-with-push; count unchanged.
- Throughput: with src_ready held 1, steady state is 1 word/cycle. First src_valid 2 cycles after accepted start (issue cycle +1, capture +1).
- Credit rule guarantees no FIFO overflow; a push into a full FIFO is a design error (assertion).
- stop (any non-IDLE state): next cycle state=IDLE, busy=0, FIFO flushed, src_valid=0, no done pulse; the read in flight, if any, is discarded (capture-suppress flag). stop in IDLE ignored. stop and start in the same cycle: stop wins.
- start while busy ignored; length/loop_en changes mid-playback have no effect.
- Asynchronous reset mid-playback returns all state to reset values immediately.
- Widths: addr counter ADDR_W bits; fifo_count log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package audio_feed_pkg: ADDR_W, DATA_W, MEM_WORDS constants; reader state enum (IDLE/FETCH/DRAIN); stereo sample struct {left[15:0], right[15:0]}.
- One sub-module: audio_feed_sample_fifo (synchronous FWFT FIFO, DATA_W x FIFO_DEPTH, push/pop/full/empty/count, flush input). Reader owns FSM, address counter, credit logic.

Test Plan:
- Memory word[i] = 0xA000_0000+i; length=5, loop_en=0, src_ready=1 -> src_data 0xA0000000..0xA0000004 on 5 consecutive cycles starting 2 cycles after start; addresses 0..4 only; done pulses once; busy drops with done.
- length=3, src_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH... reads capped at 3 issued, no overflow; words 0,1,2 delivered in order after ready rises, then done.
- length=4, loop_en=1, src_ready=1 for 14 accepts then stop -> sequence 0,1,2,3,0,1,2,3,0,1,2,3,0,1; busy=0 cycle after stop, no done, src_valid=0, FIFO empty.
- src_ready toggling 1010... with length=8 -> all 8 words delivered in order, no duplicates/drops; mem_chipselect never exceeds credit (fifo_count+inflight<=4).
- length=0 -> no mem_chipselect, done pulse next cycle, busy stays 0; length=90000 -> clamped, last address driven 79999.
- Assert reset_n low while FETCH with 2 words buffered -> all outputs reset values immediately; start after release plays from address 0.

Source files
------------

// File: rtl/audio_feed_pkg.sv
// Shared constants and types for the audio feed sample reader.
package audio_feed_pkg;

   localparam int ADDR_W     = 17;
   localparam int DATA_W     = 32;
   localparam int MEM_WORDS  = 80000;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } reader_state_t;

   typedef struct packed {
      logic [15:0] left;
      logic [15:0] right;
   } stereo_sample_t;

   function automatic stereo_sample_t make_sample(input logic [15:0] left, input logic [15:0] right);
      stereo_sample_t s;
      s.left  = left;
      s.right = right;
      return s;
   endfunction

endpackage

// File: rtl/audio_feed_sample_fifo.sv
// First-word-fall-through FIFO holding prefetched stereo words; flush empties it in one cycle.
module audio_feed_sample_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   import audio_feed_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (count_q == {CNT_W{1'b0}});
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   // Storage array; contents are meaningless while empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy; flush overrides any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else if (flush_i) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   audio_feed_sample_fifo_chk u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push_i && !flush_i),
      .pop_i   (pop_i),
      .full_i  (full_o)
   );

endmodule

// File: rtl/audio_feed_sample_fifo_chk.sv
// Property checks for the prefetch FIFO; carries no logic of its own.
module audio_feed_sample_fifo_chk (
   input logic clk,
   input logic reset_n,
   input logic push_i,
   input logic pop_i,
   input logic full_i
);

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n) (push_i && full_i) |-> pop_i);

endmodule

// File: rtl/audio_feed_sample_reader.sv
// Streams stereo words from the sample memory to the codec serializer,
// prefetching under a credit limit so the 1-cycle read latency is hidden.
module audio_feed_sample_reader #(
   parameter int ADDR_W     = audio_feed_pkg::ADDR_W,
   parameter int DATA_W     = audio_feed_pkg::DATA_W,
   parameter int MEM_WORDS  = audio_feed_pkg::MEM_WORDS,
   parameter int FIFO_DEPTH = audio_feed_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready
);
   import audio_feed_pkg::*;

   localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] MAX_LEN_C  = ADDR_W'(MEM_WORDS);
   localparam logic [ADDR_W-1:0] ADDR_ONE_C = ADDR_W'(1);
   localparam logic [CNT_W:0]    CREDIT_C   = (CNT_W + 1)'(FIFO_DEPTH);

   reader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic              loop_q, loop_d;
   logic              inflight_q, inflight_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              issue_s;
   logic              flush_s;
   logic              pop_s;
   logic              credit_ok_s;
   logic              last_addr_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;

   // Words already buffered plus the read still in flight must leave room for one more.
   assign credit_ok_s = !fifo_full_s &&
                        (({1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_q}) < CREDIT_C);
   assign last_addr_s = (addr_q == (len_q - ADDR_ONE_C));
   assign pop_s       = src_valid && src_ready;

   assign src_valid      = !fifo_empty_s;
   assign busy           = busy_q;
   assign done           = done_q;
   assign mem_address    = addr_q;
   assign mem_chipselect = issue_s;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   // Playback FSM: start/stop handling, read issue, address advance and completion.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      loop_d     = loop_q;
      done_d     = 1'b0;
      issue_s    = 1'b0;
      flush_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               len_d  = (length > MAX_LEN_C) ? MAX_LEN_C : length;
               loop_d = loop_en;
               addr_d = {ADDR_W{1'b0}};
               if (length == {ADDR_W{1'b0}}) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (stop) begin
               state_d = ST_IDLE;
               flush_s = 1'b1;
               addr_d  = {ADDR_W{1'b0}};
            end else if (credit_ok_s) begin
               issue_s = 1'b1;
               if (last_addr_s) begin
                  addr_d  = {ADDR_W{1'b0}};
                  state_d = loop_q ? ST_FETCH : ST_DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_ONE_C;
               end
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (stop) begin
               state_d = ST_IDLE;
               flush_s = 1'b1;
            end else if (!inflight_q && fifo_empty_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            flush_s = 1'b1;
            addr_d  = {ADDR_W{1'b0}};
         end
      endcase
      // Stop never issues, so no capture can land after the flush.
      inflight_d = issue_s;
      busy_d     = (state_d != ST_IDLE);
   end

   // State and control registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= {ADDR_W{1'b0}};
         len_q      <= {ADDR_W{1'b0}};
         loop_q     <= 1'b0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         loop_q     <= loop_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   audio_feed_sample_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush_s),
      .push_i  (inflight_q),
      .pop_i   (pop_s),
      .wdata_i (mem_readdata),
      .rdata_o (src_data),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_audio_feed_sample_reader.sv
// Scoreboard bench for audio_feed_sample_reader: memory model word[i] = 0xA000_0000 + i.
module tb_audio_feed_sample_reader;

   localparam int AW = 17;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic          start     = 1'b0;
   logic          stop      = 1'b0;
   logic          loop_en   = 1'b0;
   logic          src_ready = 1'b0;
   logic [AW-1:0] length    = {AW{1'b0}};
   logic [31:0]   mem_readdata = 32'h0;
   logic          busy, done, mem_chipselect, mem_write, mem_clken, src_valid;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic [31:0]   src_data;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q [$];
   int issued_cnt = 0, acc_cnt = 0, done_cnt = 0, cyc = 0;
   int acc_first = 0, acc_last = 0, credit_viol = 0, max_addr = 0, cur_len = 0;
   logic [AW-1:0] exp_addr = {AW{1'b0}};

   always #5 clk = ~clk;

   audio_feed_sample_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .stop           (stop),
      .loop_en        (loop_en),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .src_data       (src_data),
      .src_valid      (src_valid),
      .src_ready      (src_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Single-port memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= 32'hA000_0000 + 32'(mem_address);
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle monitor: issue/credit/address checks and scoreboard pops.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_chipselect) begin
            if (issued_cnt - acc_cnt >= 4) credit_viol++;
            check_eq("issue_addr", 32'(mem_address), 32'(exp_addr));
            if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
            issued_cnt++;
            exp_addr = (int'(exp_addr) + 1 == cur_len) ? {AW{1'b0}} : exp_addr + 17'd1;
         end
         if (src_valid && src_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("src_data", src_data, exp_q.pop_front());
            acc_cnt++;
            if (acc_cnt == 1) acc_first = cyc;
            acc_last = cyc;
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len, input logic lp, input int nexp);
      cur_len     = (len > 80000) ? 80000 : len;
      issued_cnt  = 0;
      acc_cnt     = 0;
      done_cnt    = 0;
      max_addr    = 0;
      credit_viol = 0;
      exp_addr    = {AW{1'b0}};
      for (int i = 0; i < nexp; i++) exp_q.push_back(32'hA000_0000 + 32'(i % cur_len));
      length  = AW'(len);
      loop_en = lp;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int budget, input logic toggle);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (toggle) src_ready = ~src_ready;
         if (done) got = 1'b1;
      end
      check_eq("done_seen", 32'(got), 32'd1);
      check_eq("busy_at_done", 32'(busy), 32'd0);
      tick();
      check_eq("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      // Reset values
      tick(); tick();
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_cs", 32'(mem_chipselect), 32'd0);
      check_eq("rst_addr", 32'(mem_address), 32'd0);
      check_eq("rst_valid", 32'(src_valid), 32'd0);
      check_eq("const_write", 32'(mem_write), 32'd0);
      check_eq("const_byteen", 32'(mem_byteenable), 32'hF);
      check_eq("const_clken", 32'(mem_clken), 32'd1);
      reset_n = 1'b1;
      tick();

      // One-shot, length 5, sink always ready
      src_ready = 1'b1;
      do_start(5, 1'b0, 5);
      check_eq("t1_busy", 32'(busy), 32'd1);
      check_eq("t1_valid_c0", 32'(src_valid), 32'd0);
      tick();
      check_eq("t1_valid_c1", 32'(src_valid), 32'd0);
      tick();
      check_eq("t1_valid_c2", 32'(src_valid), 32'd1);
      wait_done(40, 1'b0);
      check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
      check_eq("t1_issued", 32'(issued_cnt), 32'd5);
      check_eq("t1_accepted", 32'(acc_cnt), 32'd5);
      check_eq("t1_max_addr", 32'(max_addr), 32'd4);
      check_eq("t1_back_to_back", 32'(acc_last - acc_first), 32'd4);
      check_eq("t1_sb_left", 32'(exp_q.size()), 32'd0);

      // Sink stalled: issues capped by length, then drained in order
      src_ready = 1'b0;
      do_start(3, 1'b0, 3);
      repeat (20) tick();
      check_eq("t2_issued", 32'(issued_cnt), 32'd3);
      check_eq("t2_valid", 32'(src_valid), 32'd1);
      check_eq("t2_busy", 32'(busy), 32'd1);
      src_ready = 1'b1;
      wait_done(20, 1'b0);
      check_eq("t2_accepted", 32'(acc_cnt), 32'd3);
      check_eq("t2_sb_left", 32'(exp_q.size()), 32'd0);
      check_eq("t2_credit", 32'(credit_viol), 32'd0);

      // Looped playback, stop after 14 words
      src_ready = 1'b1;
      do_start(4, 1'b1, 14);
      for (int i = 0; i < 80 && acc_cnt < 14; i++) tick();
      check_eq("t3_accepts", 32'(acc_cnt), 32'd14);
      src_ready = 1'b0;
      stop      = 1'b1;
      tick();
      stop      = 1'b0;
      check_eq("t3_busy_after_stop", 32'(busy), 32'd0);
      check_eq("t3_valid_after_stop", 32'(src_valid), 32'd0);
      check_eq("t3_no_done", 32'(done), 32'd0);
      src_ready = 1'b1;
      tick(); tick();
      check_eq("t3_valid_flushed", 32'(src_valid), 32'd0);
      check_eq("t3_cs_idle", 32'(mem_chipselect), 32'd0);
      check_eq("t3_done_cnt", 32'(done_cnt), 32'd0);
      check_eq("t3_sb_left", 32'(exp_q.size()), 32'd0);

      // Sink toggling every cycle
      src_ready = 1'b1;
      do_start(8, 1'b0, 8);
      wait_done(60, 1'b1);
      check_eq("t4_accepted", 32'(acc_cnt), 32'd8);
      check_eq("t4_sb_left", 32'(exp_q.size()), 32'd0);
      check_eq("t4_credit", 32'(credit_viol), 32'd0);

      // Zero length
      src_ready = 1'b1;
      do_start(0, 1'b0, 0);
      check_eq("t5_done", 32'(done), 32'd1);
      check_eq("t5_busy", 32'(busy), 32'd0);
      tick();
      check_eq("t5_done_low", 32'(done), 32'd0);
      check_eq("t5_busy_low", 32'(busy), 32'd0);
      check_eq("t5_issued", 32'(issued_cnt), 32'd0);

      // Over-long length clamps to the memory depth
      do_start(90000, 1'b0, 80000);
      wait_done(80100, 1'b0);
      check_eq("t5_clamp_max_addr", 32'(max_addr), 32'd79999);
      check_eq("t5_clamp_issued", 32'(issued_cnt), 32'd80000);
      check_eq("t5_clamp_accepted", 32'(acc_cnt), 32'd80000);
      check_eq("t5_clamp_sb_left", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while fetching with two words buffered
      src_ready = 1'b0;
      do_start(10, 1'b0, 0);
      tick(); tick(); tick();
      check_eq("t6_pre_valid", 32'(src_valid), 32'd1);
      check_eq("t6_pre_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_done", 32'(done), 32'd0);
      check_eq("t6_rst_cs", 32'(mem_chipselect), 32'd0);
      check_eq("t6_rst_addr", 32'(mem_address), 32'd0);
      check_eq("t6_rst_valid", 32'(src_valid), 32'd0);
      #2;
      reset_n = 1'b1;
      tick();
      src_ready = 1'b1;
      do_start(3, 1'b0, 3);
      wait_done(30, 1'b0);
      check_eq("t6_accepted", 32'(acc_cnt), 32'd3);
      check_eq("t6_sb_left", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
